// File: rtl/rv32v_lane_sequencer.sv
// Two-lane vector element sequencer: steps an element index by two per unstalled beat.
// Optional `RV32V_MASK_EN gates lane write enables with the latched v0 mask.
module rv32v_lane_sequencer #(
  parameter int unsigned IDX_W = 5
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [IDX_W:0]        vl,
  input  logic                  stall_ex,
  input  logic                  flush_ex,
  input  logic                  vm,
  input  logic [2**IDX_W-1:0]   vmask,
  output logic [IDX_W-1:0]      woffset0,
  output logic [IDX_W-1:0]      woffset1,
  output logic                  wen0,
  output logic                  wen1,
  output logic                  busy,
  output logic                  stall_dec,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [IDX_W:0] MaxVl = {1'b1, {IDX_W{1'b0}}};

  state_e            state_q, state_d;
  logic [IDX_W:0]    idx_q, idx_d;
  logic [IDX_W:0]    vl_q, vl_d;
  logic [IDX_W:0]    vl_clamp;
  logic [IDX_W+1:0]  idx_ext, idx_p1, idx_p2, vl_ext;

  assign vl_clamp = (vl > MaxVl) ? MaxVl : vl;
  assign idx_ext  = {1'b0, idx_q};
  assign idx_p1   = idx_ext + (IDX_W+2)'(1);
  assign idx_p2   = idx_ext + (IDX_W+2)'(2);
  assign vl_ext   = {1'b0, vl_q};

`ifdef RV32V_MASK_EN
  logic [2**IDX_W-1:0] mask_q, mask_d;
`else
  logic unused_mask_inputs;
  assign unused_mask_inputs = &{1'b0, vm, vmask};
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vl_d    = vl_q;
`ifdef RV32V_MASK_EN
    mask_d  = mask_q;
`endif
    // flush outranks everything; start is only honoured outside RUN
    if (flush_ex) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (start && state_q != RUN) begin
      vl_d    = vl_clamp;
      idx_d   = '0;
      state_d = (vl_clamp != '0) ? RUN : DONE;
`ifdef RV32V_MASK_EN
      mask_d  = vmask;
`endif
    end else begin
      case (state_q)
        RUN: if (!stall_ex) begin
          idx_d = idx_p2[IDX_W:0];
          if (idx_p2 >= vl_ext) state_d = DONE;
        end
        DONE: if (!stall_ex) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vl_q    <= '0;
`ifdef RV32V_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vl_q    <= vl_d;
`ifdef RV32V_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  always_comb begin
    woffset0  = '0;
    woffset1  = '0;
    wen0      = 1'b0;
    wen1      = 1'b0;
    busy      = (state_q == RUN);
    stall_dec = (state_q == RUN);
    done      = (state_q == DONE);
    if (state_q == RUN) begin
      woffset0 = idx_q[IDX_W-1:0];
      woffset1 = idx_q[IDX_W-1:0] + IDX_W'(1);
      wen0     = (idx_ext < vl_ext);
      wen1     = (idx_p1 < vl_ext);
`ifdef RV32V_MASK_EN
      wen0     = wen0 & (vm | mask_q[woffset0]);
      wen1     = wen1 & (vm | mask_q[woffset1]);
`endif
    end
  end

endmodule

// File: tb/tb_rv32v_lane_sequencer.sv
// Directed bench for rv32v_lane_sequencer: hand-computed beat sequences per scenario.
module tb_rv32v_lane_sequencer;

  localparam int unsigned IDX_W = 5;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              start;
  logic [IDX_W:0]    vl;
  logic              stall_ex;
  logic              flush_ex;
  logic              vm;
  logic [31:0]       vmask;
  logic [IDX_W-1:0]  woffset0, woffset1;
  logic              wen0, wen1, busy, stall_dec, done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 CLK = ~CLK;

  rv32v_lane_sequencer #(.IDX_W(IDX_W)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .vl(vl), .stall_ex(stall_ex),
    .flush_ex(flush_ex), .vm(vm), .vmask(vmask),
    .woffset0(woffset0), .woffset1(woffset1), .wen0(wen0), .wen1(wen1),
    .busy(busy), .stall_dec(stall_dec), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // packed as {stall_dec, busy, done, wen0, wen1, woffset0, woffset1}
  task automatic expect_out(input string tag, input logic b, input logic d,
                            input logic w0, input logic w1,
                            input int unsigned o0, input int unsigned o1);
    logic [4:0] e0, e1;
    e0 = 5'(o0);
    e1 = 5'(o1);
    check(tag, {17'd0, stall_dec, busy, done, wen0, wen1, woffset0, woffset1},
               {17'd0, b, b, d, w0, w1, e0, e1});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input int unsigned len);
    start = 1'b1;
    vl    = 6'(len);
    tick();
    start = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; vl = '0; stall_ex = 1'b0; flush_ex = 1'b0;
    vm = 1'b1; vmask = '0;
    #12;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    nRST = 1'b1;
    tick();
    expect_out("idle_after_reset", 0, 0, 0, 0, 0, 0);

    issue(4);
    expect_out("vl4_b0", 1, 0, 1, 1, 0, 1);
    tick(); expect_out("vl4_b1", 1, 0, 1, 1, 2, 3);
    tick(); expect_out("vl4_done", 0, 1, 0, 0, 0, 0);
    tick(); expect_out("vl4_idle", 0, 0, 0, 0, 0, 0);

    issue(5);
    expect_out("vl5_b0", 1, 0, 1, 1, 0, 1);
    tick(); expect_out("vl5_b1", 1, 0, 1, 1, 2, 3);
    tick(); expect_out("vl5_b2", 1, 0, 1, 0, 4, 5);
    tick(); expect_out("vl5_done", 0, 1, 0, 0, 0, 0);
    tick();

    issue(6);
    expect_out("vl6_b0", 1, 0, 1, 1, 0, 1);
    tick(); expect_out("vl6_b1", 1, 0, 1, 1, 2, 3);
    stall_ex = 1'b1;
    tick(); expect_out("vl6_stall1", 1, 0, 1, 1, 2, 3);
    tick(); expect_out("vl6_stall2", 1, 0, 1, 1, 2, 3);
    stall_ex = 1'b0;
    tick(); expect_out("vl6_b2", 1, 0, 1, 1, 4, 5);
    tick(); expect_out("vl6_done", 0, 1, 0, 0, 0, 0);
    tick();

    issue(8);
    tick(); expect_out("vl8_b1", 1, 0, 1, 1, 2, 3);
    flush_ex = 1'b1;
    tick(); expect_out("flush_idle", 0, 0, 0, 0, 0, 0);
    flush_ex = 1'b0;
    tick(); expect_out("flush_no_done", 0, 0, 0, 0, 0, 0);

    issue(0);
    expect_out("vl0_done", 0, 1, 0, 0, 0, 0);
    tick(); expect_out("vl0_idle", 0, 0, 0, 0, 0, 0);

    start = 1'b1; flush_ex = 1'b1; vl = 6'd4;
    tick(); expect_out("flush_beats_start", 0, 0, 0, 0, 0, 0);
    start = 1'b0; flush_ex = 1'b0;

    vm = 1'b0; vmask = 32'h5;
    issue(4);
`ifdef RV32V_MASK_EN
    expect_out("mask_b0", 1, 0, 1, 0, 0, 1);
    tick(); expect_out("mask_b1", 1, 0, 1, 0, 2, 3);
`else
    expect_out("nomask_b0", 1, 0, 1, 1, 0, 1);
    tick(); expect_out("nomask_b1", 1, 0, 1, 1, 2, 3);
`endif
    tick(); tick();
    vm = 1'b1;
    issue(4);
    expect_out("vm1_b0", 1, 0, 1, 1, 0, 1);
    tick(); expect_out("vm1_b1", 1, 0, 1, 1, 2, 3);
    tick(); tick();

    start = 1'b1; vl = 6'd2;
    tick(); expect_out("b2b_run1", 1, 0, 1, 1, 0, 1);
    tick(); expect_out("b2b_done1", 0, 1, 0, 0, 0, 0);
    tick(); expect_out("b2b_run2", 1, 0, 1, 1, 0, 1);
    start = 1'b0;
    tick(); expect_out("b2b_done2", 0, 1, 0, 0, 0, 0);
    stall_ex = 1'b1;
    tick(); expect_out("done_stall_hold", 0, 1, 0, 0, 0, 0);
    stall_ex = 1'b0;
    tick(); expect_out("done_to_idle", 0, 0, 0, 0, 0, 0);

    issue(40);
    for (int i = 0; i < 16; i++) begin
      expect_out($sformatf("vl40_b%0d", i), 1, 0, 1, 1, 2*i, (2*i+1) % 32);
      tick();
    end
    expect_out("vl40_done", 0, 1, 0, 0, 0, 0);
    tick();

    issue(8);
    tick();
    nRST = 1'b0;
    #1;
    expect_out("async_reset_mid_run", 0, 0, 0, 0, 0, 0);
    #3;
    nRST = 1'b1;
    tick(); expect_out("after_reset_no_done", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
